// File: rtl/yasac_control_unit.sv
// rtl/yasac_control_unit.sv - YASAC fetch/decode/execute control unit
module yasac_control_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [7:0]  imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_data_i,
    input  logic [7:0]  st_i,
    output logic [3:0]  alu_operation_o,
    output logic [2:0]  rd_sel_o,
    output logic [2:0]  rs_sel_o,
    output logic        b_imm_o,
    output logic [7:0]  imm_o,
    output logic        reg_we_o,
    output logic        st_we_o,
    output logic        halted_o,
    output logic        illegal_o
);

    // ALU operation codes shared with the datapath
    localparam logic [3:0] ALU_TRA = 4'd0;
    localparam logic [3:0] ALU_TRB = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_AND = 4'd4;
    localparam logic [3:0] ALU_OR  = 4'd5;
    localparam logic [3:0] ALU_EOR = 4'd6;
    localparam logic [3:0] ALU_NEG = 4'd7;
    localparam logic [3:0] ALU_ROR = 4'd8;
    localparam logic [3:0] ALU_ROL = 4'd9;

    // Status register bit positions (---SVNZC)
    localparam int CF = 0;
    localparam int ZF = 1;
    localparam int NF = 2;
    localparam int SF = 4;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_DECODE  = 2'd1,
        S_EXECUTE = 2'd2,
        S_HALT    = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;

    logic [3:0]  opcode;
    logic        dec_reg_we;
    logic        dec_st_we;
    logic        br_taken;
    logic        in_exec;

    // Overflow flag and IR[11] are not consumed by this controller
    logic        unused_bits;
    assign unused_bits = &{1'b0, st_i[7:5], st_i[3], ir_q[11]};

    assign opcode      = ir_q[15:12];
    assign rd_sel_o    = ir_q[10:8];
    assign rs_sel_o    = ir_q[2:0];
    assign imm_o       = ir_q[7:0];
    assign imem_addr_o = pc_q;
    assign in_exec     = (state_q == S_EXECUTE);

    // Request is masked while reset is held, since the state already reads FETCH
    assign imem_req_o  = (state_q == S_FETCH) && !rst_i;
    assign reg_we_o    = in_exec && dec_reg_we;
    assign st_we_o     = in_exec && dec_st_we;
    assign illegal_o   = in_exec && (opcode == 4'hE);
    assign halted_o    = (state_q == S_HALT);

    // Opcode decode: ALU operation, operand B source and write enables
    always_comb begin
        alu_operation_o = ALU_TRA;
        b_imm_o         = 1'b0;
        dec_reg_we      = 1'b0;
        dec_st_we       = 1'b0;
        case (opcode)
            4'h1: begin alu_operation_o = ALU_ADD; dec_reg_we = 1'b1; dec_st_we = 1'b1; end
            4'h2: begin alu_operation_o = ALU_SUB; dec_reg_we = 1'b1; dec_st_we = 1'b1; end
            4'h3: begin alu_operation_o = ALU_AND; dec_reg_we = 1'b1; dec_st_we = 1'b1; end
            4'h4: begin alu_operation_o = ALU_OR;  dec_reg_we = 1'b1; dec_st_we = 1'b1; end
            4'h5: begin alu_operation_o = ALU_EOR; dec_reg_we = 1'b1; dec_st_we = 1'b1; end
            4'h6: begin alu_operation_o = ALU_TRB; dec_reg_we = 1'b1; end
            4'h7: begin alu_operation_o = ALU_NEG; dec_reg_we = 1'b1; dec_st_we = 1'b1; end
            4'h8: begin alu_operation_o = ALU_ROR; dec_reg_we = 1'b1; dec_st_we = 1'b1; end
            4'h9: begin alu_operation_o = ALU_ROL; dec_reg_we = 1'b1; dec_st_we = 1'b1; end
            4'hA: begin alu_operation_o = ALU_TRB; b_imm_o = 1'b1; dec_reg_we = 1'b1; end
            4'hB: begin alu_operation_o = ALU_SUB; dec_st_we = 1'b1; end
            default: ;
        endcase
    end

    // Branch condition evaluated against the live status register
    always_comb begin
        br_taken = 1'b0;
        case (ir_q[10:8])
            3'b000: br_taken =  st_i[ZF];
            3'b001: br_taken = !st_i[ZF];
            3'b010: br_taken =  st_i[CF];
            3'b011: br_taken = !st_i[CF];
            3'b100: br_taken =  st_i[NF];
            3'b101: br_taken = !st_i[NF];
            3'b110: br_taken =  st_i[SF];
            3'b111: br_taken = !st_i[SF];
            default: br_taken = 1'b0;
        endcase
    end

    // Next-state, PC and IR update
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_FETCH: begin
                if (imem_ack_i) begin
                    ir_d    = imem_data_i;
                    pc_d    = pc_q + 8'd1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXECUTE;
            S_EXECUTE: begin
                state_d = S_FETCH;
                case (opcode)
                    4'hC: if (br_taken) pc_d = pc_q + ir_q[7:0];
                    4'hD: pc_d = ir_q[7:0];
                    4'hF: state_d = S_HALT;
                    default: ;
                endcase
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // State, PC and instruction registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_yasac_control_unit.sv
// tb/tb_yasac_control_unit.sv - directed vector bench for yasac_control_unit
module tb_yasac_control_unit;

    localparam logic [3:0] TRA = 4'd0, TRB = 4'd1, ADD = 4'd2, SUB = 4'd3, AND_ = 4'd4;
    localparam logic [3:0] OR_ = 4'd5, EOR = 4'd6, NEG = 4'd7, ROR = 4'd8, ROL = 4'd9;
    localparam int NV = 29;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] instr;
        logic [7:0]  st;
        logic [3:0]  waits;
        logic [3:0]  alu;
        logic [2:0]  rd;
        logic [2:0]  rs;
        logic        bimm;
        logic [7:0]  imm;
        logic        rwe;
        logic        swe;
        logic        ill;
        logic [7:0]  nxt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [7:0]  st;
    logic [3:0]  alu_op;
    logic [2:0]  rd_sel;
    logic [2:0]  rs_sel;
    logic        b_imm;
    logic [7:0]  imm;
    logic        reg_we;
    logic        st_we;
    logic        halted;
    logic        illegal;

    int          n_vec = 0;
    int          n_err = 0;
    logic [2:0]  prev_rd;
    vec_t        vecs [NV];

    always #5 clk = ~clk;

    yasac_control_unit #(.RESET_PC(8'h10)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .imem_req_o     (imem_req),
        .imem_addr_o    (imem_addr),
        .imem_ack_i     (imem_ack),
        .imem_data_i    (imem_data),
        .st_i           (st),
        .alu_operation_o(alu_op),
        .rd_sel_o       (rd_sel),
        .rs_sel_o       (rs_sel),
        .b_imm_o        (b_imm),
        .imm_o          (imm),
        .reg_we_o       (reg_we),
        .st_we_o        (st_we),
        .halted_o       (halted),
        .illegal_o      (illegal)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Fetch with optional wait states, then check DECODE, EXECUTE and the next fetch
    task automatic run_vec(input vec_t v);
        imem_data = v.instr;
        imem_ack  = 1'b0;
        for (int w = 0; w < int'(v.waits); w++) begin
            #1;
            check("wait_req_addr", {imem_req, imem_addr}, {1'b1, v.pc});
            check("wait_ir_hold", {29'd0, rd_sel}, {29'd0, prev_rd});
            @(negedge clk);
        end
        #1;
        check("fetch_req_addr", {imem_req, imem_addr}, {1'b1, v.pc});
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
        check("decode_quiet", {imem_req, reg_we, st_we, illegal, rd_sel},
              {1'b0, 3'b000, v.rd});
        st = v.st;
        @(negedge clk);
        #1;
        check("exec_decode", {alu_op, rd_sel, rs_sel, b_imm, imm},
              {v.alu, v.rd, v.rs, v.bimm, v.imm});
        check("exec_strobes", {reg_we, st_we, illegal, halted},
              {v.rwe, v.swe, v.ill, 1'b0});
        @(negedge clk);
        #1;
        check("next_fetch", {imem_req, imem_addr, reg_we, st_we, illegal},
              {1'b1, v.nxt, 3'b000});
        prev_rd = v.rd;
    endtask

    initial begin
        //         pc     instr     st     w  alu  rd    rs    bi  imm    rwe   swe   ill  nxt
        vecs[0]  = '{8'h10, 16'hA105, 8'h00, 4'd3, TRB, 3'd1, 3'd5, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 8'h11};
        vecs[1]  = '{8'h11, 16'h1234, 8'h00, 4'd0, ADD, 3'd2, 3'd4, 1'b0, 8'h34, 1'b1, 1'b1, 1'b0, 8'h12};
        vecs[2]  = '{8'h12, 16'h2305, 8'h00, 4'd1, SUB, 3'd3, 3'd5, 1'b0, 8'h05, 1'b1, 1'b1, 1'b0, 8'h13};
        vecs[3]  = '{8'h13, 16'h3001, 8'h00, 4'd0, AND_,3'd0, 3'd1, 1'b0, 8'h01, 1'b1, 1'b1, 1'b0, 8'h14};
        vecs[4]  = '{8'h14, 16'h4702, 8'h00, 4'd0, OR_, 3'd7, 3'd2, 1'b0, 8'h02, 1'b1, 1'b1, 1'b0, 8'h15};
        vecs[5]  = '{8'h15, 16'h5106, 8'h00, 4'd0, EOR, 3'd1, 3'd6, 1'b0, 8'h06, 1'b1, 1'b1, 1'b0, 8'h16};
        vecs[6]  = '{8'h16, 16'h6203, 8'h00, 4'd0, TRB, 3'd2, 3'd3, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 8'h17};
        vecs[7]  = '{8'h17, 16'h7400, 8'h00, 4'd0, NEG, 3'd4, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h18};
        vecs[8]  = '{8'h18, 16'h8500, 8'h00, 4'd0, ROR, 3'd5, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h19};
        vecs[9]  = '{8'h19, 16'h9600, 8'h00, 4'd0, ROL, 3'd6, 3'd0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h1A};
        vecs[10] = '{8'h1A, 16'h0000, 8'h00, 4'd0, TRA, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h1B};
        vecs[11] = '{8'h1B, 16'hE000, 8'h00, 4'd0, TRA, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h1C};
        vecs[12] = '{8'h1C, 16'hD020, 8'h00, 4'd0, TRA, 3'd0, 3'd0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 8'h20};
        vecs[13] = '{8'h20, 16'hB102, 8'h00, 4'd0, SUB, 3'd1, 3'd2, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 8'h21};
        vecs[14] = '{8'h21, 16'hC004, 8'h02, 4'd0, TRA, 3'd0, 3'd4, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 8'h26};
        vecs[15] = '{8'h26, 16'hD020, 8'h00, 4'd0, TRA, 3'd0, 3'd0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 8'h20};
        vecs[16] = '{8'h20, 16'hB102, 8'h00, 4'd0, SUB, 3'd1, 3'd2, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 8'h21};
        vecs[17] = '{8'h21, 16'hC004, 8'h00, 4'd0, TRA, 3'd0, 3'd4, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 8'h22};
        vecs[18] = '{8'h22, 16'hD030, 8'h00, 4'd0, TRA, 3'd0, 3'd0, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 8'h30};
        vecs[19] = '{8'h30, 16'hC7FE, 8'h00, 4'd0, TRA, 3'd7, 3'd6, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0, 8'h2F};
        vecs[20] = '{8'h2F, 16'hC105, 8'h02, 4'd0, TRA, 3'd1, 3'd5, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0, 8'h30};
        vecs[21] = '{8'h30, 16'hC203, 8'h01, 4'd0, TRA, 3'd2, 3'd3, 1'b0, 8'h03, 1'b0, 1'b0, 1'b0, 8'h34};
        vecs[22] = '{8'h34, 16'hC3F0, 8'h01, 4'd0, TRA, 3'd3, 3'd0, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 8'h35};
        vecs[23] = '{8'h35, 16'hC410, 8'h04, 4'd0, TRA, 3'd4, 3'd0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 8'h46};
        vecs[24] = '{8'h46, 16'hC510, 8'h04, 4'd0, TRA, 3'd5, 3'd0, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 8'h47};
        vecs[25] = '{8'h47, 16'hC602, 8'h10, 4'd0, TRA, 3'd6, 3'd2, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 8'h4A};
        vecs[26] = '{8'h4A, 16'hC702, 8'h10, 4'd0, TRA, 3'd7, 3'd2, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 8'h4B};
        vecs[27] = '{8'h4B, 16'hD0FF, 8'h00, 4'd0, TRA, 3'd0, 3'd7, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hFF};
        vecs[28] = '{8'hFF, 16'h0000, 8'h00, 4'd2, TRA, 3'd0, 3'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};

        rst       = 1'b1;
        imem_ack  = 1'b1;
        imem_data = 16'hA105;
        st        = 8'h00;
        prev_rd   = 3'd0;

        // Reset state: no request, no strobes, not halted
        @(negedge clk);
        #1;
        check("reset_outputs", {imem_req, reg_we, st_we, illegal, halted, imem_addr},
              {5'b00000, 8'h10});
        @(negedge clk);
        rst      = 1'b0;
        imem_ack = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_vec(vecs[i]);
        end

        // HALT: terminal, ignores acks, no request or strobes
        imem_data = 16'hF000;
        #1;
        check("halt_fetch_addr", {imem_req, imem_addr}, {1'b1, 8'h00});
        imem_ack = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        #1;
        check("halt_exec", {halted, reg_we, st_we, illegal}, 4'b0000);
        @(negedge clk);
        for (int c = 0; c < 20; c++) begin
            imem_ack = c[0];
            #1;
            check("halt_hold", {halted, imem_req, reg_we, st_we, illegal, imem_addr},
                  {5'b10000, 8'h01});
            @(negedge clk);
        end
        imem_ack = 1'b0;
        rst = 1'b1;
        #1;
        check("halt_reset", {halted, imem_req, imem_addr}, {2'b00, 8'h10});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("halt_release", {imem_req, imem_addr}, {1'b1, 8'h10});

        // Reset during EXECUTE of ADD aborts the write strobes at once
        imem_data = 16'h1234;
        imem_ack  = 1'b1;
        @(negedge clk);
        imem_ack = 1'b0;
        @(negedge clk);
        #1;
        check("abort_pre", {reg_we, st_we, alu_op}, {2'b11, ADD});
        rst = 1'b1;
        #1;
        check("abort_strobes", {reg_we, st_we, imem_req, imem_addr}, {3'b000, 8'h10});
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_release", {imem_req, imem_addr, rd_sel}, {1'b1, 8'h10, 3'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/yasac_control_unit.md
Name: yasac_control_unit

Overview:
- Multi-cycle fetch/decode/execute controller for the 8-bit YASAC datapath; it is the driving end of the ALU interface.
- Fetches 16-bit instructions over a req/ack instruction-memory port and decodes them into the ALU operation code, register-file selects and write strobes.
- Consumes the status register (---SVNZC) for conditional branches.
- ALU codes are the `ALU_* macros and flag positions are the `CF/`ZF/`NF/`VF/`SF macros from globals.vh.

Parameters:
RESET_PC, 8'h00, PC value loaded on reset

Ports:
CLK  in  1  system clock, rising edge
RESET  in  1  asynchronous, active-high reset
IMEM_REQ  out  1  instruction fetch request
IMEM_ADDR  out  8  fetch address (current PC)
IMEM_ACK  in  1  instruction data valid this cycle
IMEM_DATA  in  16  instruction word, sampled when IMEM_REQ&IMEM_ACK
ST  in  8  current status register contents
ALU_OPERATION  out  4  ALU operation code
RD_SEL  out  3  destination / operand A register (IR[10:8])
RS_SEL  out  3  operand B register (IR[2:0])
B_IMM  out  1  1: ALU operand B = IMM, 0: register RS
IMM  out  8  immediate (IR[7:0])
REG_WE  out  1  register-file write strobe, one cycle
ST_WE  out  1  status-register write strobe (latch ALU ST_OUT), one cycle
HALTED  out  1  core halted
ILLEGAL  out  1  one-cycle pulse on reserved opcode

Behaviour:
- Reset (async, immediate):
  - State=FETCH, PC=RESET_PC, IR=16'h0000.
  - All strobes 0, HALTED=0, ILLEGAL=0.
  - IMEM_REQ is 0 while RESET is high and rises the first cycle after release.
- States: FETCH, DECODE, EXECUTE, HALT.
- FETCH:
  - IMEM_REQ=1, IMEM_ADDR=PC. Stay until IMEM_ACK; unbounded wait states are allowed.
  - On ack: IR<=IMEM_DATA, PC<=PC+1 (8-bit wrap, FF->00), go to DECODE.
  - IMEM_ACK is ignored when not in FETCH.
- DECODE: one cycle, no strobes. Selects settle. Go to EXECUTE.
- EXECUTE: one cycle. Strobes pulse per opcode, then go to FETCH (HALT opcode goes to HALT).
- Instruction cost: minimum 3 cycles with zero-wait memory.
- RD_SEL, RS_SEL, IMM and ALU_OPERATION decode combinationally from IR in all states. Strobes are asserted only in EXECUTE.
- Opcode IR[15:12]:
  - 0 NOP: no strobes.
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 EOR: ALU op as named, B_IMM=0, REG_WE=1, ST_WE=1.
  - 6 MOV: ALU_TRB, B_IMM=0, REG_WE=1, ST_WE=0.
  - 7 NEG, 8 ROR, 9 ROL: single operand Rd, REG_WE=1, ST_WE=1.
  - A LDI Rd,imm8: ALU_TRB, B_IMM=1, REG_WE=1, ST_WE=0.
  - B CP Rd,Rs: ALU_SUB, REG_WE=0, ST_WE=1.
  - C BRcc: cond=IR[10:8]; if taken, PC<=PC+IR[7:0] (two's-complement offset, relative to the already-incremented PC, 8-bit wrap). Not taken: PC unchanged.
  - D JMP: PC<=IR[7:0].
  - E reserved: NOP semantics, ILLEGAL=1 for the EXECUTE cycle.
  - F HALT: go to HALT.
- Branch conditions:
  - 000 EQ Z=1; 001 NE Z=0; 010 CS C=1; 011 CC C=0.
  - 100 MI N=1; 101 PL N=0; 110 LT S=1; 111 GE S=0.
  - ST is sampled in EXECUTE.
- Flag ordering: an ST_WE in EXECUTE of instruction k updates ST at that edge, so a branch k+1 sees the new flags.
- ALU_OPERATION for NOP/branch/JMP/HALT/reserved: ALU_TRA (don't-care, but defined).
- HALT: terminal. HALTED=1, IMEM_REQ=0, no strobes. Exit only via RESET.
- Reset mid-FETCH/EXECUTE aborts the instruction with no write strobe emitted.

Test Plan:
- Reset with RESET_PC=8'h10 → IMEM_REQ=1, IMEM_ADDR=8'h10 one cycle after release; ack with 16'hA105 (LDI R1,5) → EXECUTE asserts REG_WE=1, B_IMM=1, IMM=8'h05, RD_SEL=1, ST_WE=0; next IMEM_ADDR=8'h11.
- IMEM_ACK delayed 3 cycles → IMEM_REQ held 4 cycles at the same address; IR loads only on the ack cycle.
- CP R1,R2 (16'hB102) then BREQ +4 (16'hC004) at PC 0x20, ST Z=1 → next fetch 0x26. Same with Z=0 → 0x22. BRGE -2 (16'hC7FE) with S=0 at 0x30 → fetch 0x2F.
- PC wrap: NOP at 0xFF → next fetch 0x00. JMP 0x80 (16'hD080) → fetch 0x80.
- Opcode 16'hE000 → ILLEGAL pulses exactly 1 cycle, no REG_WE/ST_WE. HALT 16'hF000 → HALTED=1, IMEM_REQ=0 for 20 cycles despite IMEM_ACK toggling; RESET clears it.
- Assert RESET during EXECUTE of ADD → REG_WE/ST_WE drop immediately, PC=RESET_PC.
